// File: rtl/regfile_mp.sv
// ---------------------------------------------------------------------------
// regfile_mp -- multi-read-port register file with sequential clear engine.
//
// A DEPTH x DATA_WIDTH register array with NUM_RD combinational read ports,
// one synchronous write port, a non-bypassing debug read port and a
// two-state clear engine that zeroes the array one entry per cycle.
//
// Ports
//   clk         : clock, all state updates on the rising edge
//   i_rst_n     : asynchronous active-low reset (zeroes array, idles FSM)
//   i_raddr     : packed read addresses, port k at [k*ADDR_WIDTH +: ADDR_WIDTH]
//   o_rdata     : packed read data,      port k at [k*DATA_WIDTH +: DATA_WIDTH]
//   i_waddr     : write address
//   i_wdata     : write data
//   i_wen       : write enable (ignored while busy)
//   i_clr       : one-cycle request to start a sequential clear
//   o_busy      : high exactly while the clear FSM is in CLEAR
//   i_dbg_addr  : debug read address
//   o_dbg_data  : debug read data (array contents only, never forwarded)
//
// Handshake: there is no valid/ready pairing. A write is taken at a rising
// edge whenever i_wen=1 and o_busy=0; i_clr is sampled only when o_busy=0,
// and o_busy itself is the observable FSM state (1 = CLEAR, 0 = IDLE).
// ---------------------------------------------------------------------------
module regfile_mp #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_RD     = 2,
    parameter int BYPASS     = 1,
    parameter int ZERO_REG   = 1
) (
    input  logic                           clk,
    input  logic                           i_rst_n,
    input  logic [NUM_RD*ADDR_WIDTH-1:0]   i_raddr,
    output logic [NUM_RD*DATA_WIDTH-1:0]   o_rdata,
    input  logic [ADDR_WIDTH-1:0]          i_waddr,
    input  logic [DATA_WIDTH-1:0]          i_wdata,
    input  logic                           i_wen,
    input  logic                           i_clr,
    output logic                           o_busy,
    input  logic [ADDR_WIDTH-1:0]          i_dbg_addr,
    output logic [DATA_WIDTH-1:0]          o_dbg_data
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   cnt, cnt_nxt;
    logic                    cnt_last;
    logic                    wr_fire;
    logic                    fwd_en;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    // True when the address names the hardwired-zero register.
    function automatic logic is_zero_reg(input logic [ADDR_WIDTH-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // ------------------------------------------------------------------
    // Clear FSM
    // ------------------------------------------------------------------
    assign cnt_last = (cnt == {ADDR_WIDTH{1'b1}});
    assign o_busy   = (state == S_CLEAR);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                if (i_clr) begin
                    state_nxt = S_CLEAR;
                    cnt_nxt   = '0;
                end
            end
            S_CLEAR: begin
                // Counter wraps naturally from DEPTH-1 back to 0.
                cnt_nxt = cnt + 1'b1;
                if (cnt_last) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Storage. Each entry is its own register so the whole array can be
    // zeroed asynchronously; the clear engine has priority over writes,
    // though writes are already blocked while busy.
    // ------------------------------------------------------------------
    assign wr_fire = i_wen && !o_busy && !is_zero_reg(i_waddr);

    for (genvar g = 0; g < DEPTH; g++) begin : g_ent
        logic [DATA_WIDTH-1:0] q;

        always_ff @(posedge clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                q <= '0;
            end else if (o_busy && (cnt == ADDR_WIDTH'(g))) begin
                q <= '0;
            end else if (wr_fire && (i_waddr == ADDR_WIDTH'(g))) begin
                q <= i_wdata;
            end
        end

        assign mem[g] = q;
    end

    // ------------------------------------------------------------------
    // Read ports. Forwarding is gated by reset so that an i_wen held high
    // during reset cannot leak i_wdata onto the read bus.
    // ------------------------------------------------------------------
    assign fwd_en = (BYPASS != 0) && wr_fire && i_rst_n;

    always_comb begin
        o_rdata = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            logic [ADDR_WIDTH-1:0] ra;
            logic [DATA_WIDTH-1:0] rv;
            ra = i_raddr[k*ADDR_WIDTH +: ADDR_WIDTH];
            rv = is_zero_reg(ra) ? '0 : mem[ra];
            if (fwd_en && (ra == i_waddr)) begin
                rv = i_wdata;
            end
            o_rdata[k*DATA_WIDTH +: DATA_WIDTH] = rv;
        end
    end

    assign o_dbg_data = is_zero_reg(i_dbg_addr) ? '0 : mem[i_dbg_addr];

endmodule

// File: tb/tb_regfile_mp.sv
// ---------------------------------------------------------------------------
// tb_regfile_mp -- scoreboard bench for regfile_mp.
//
// Three instances share clock and reset:
//   dut0 : defaults (BYPASS=1)
//   dut1 : BYPASS=0, driven with the same inputs as dut0
//   dut2 : NUM_RD=4, ADDR_WIDTH=3, DATA_WIDTH=16
// The driver sets inputs just after a rising edge and pushes (tag, expected)
// pairs; the monitor drains the queue on the following falling edge, reading
// the output named by each tag.
// ---------------------------------------------------------------------------
module tb_regfile_mp;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // shared stimulus for dut0/dut1
  logic [4:0]  raddr0, raddr1, waddr, dbg_addr;
  logic [31:0] wdata;
  logic        wen, clr;
  logic [63:0] rdata0, rdata1;
  logic [31:0] dbg0, dbg1;
  logic        busy0, busy1;

  // dut2 stimulus
  logic [11:0] d2_raddr;
  logic [2:0]  d2_waddr, d2_dbg;
  logic [15:0] d2_wdata;
  logic        d2_wen, d2_clr;
  logic [63:0] rdata2;
  logic [15:0] dbg2;
  logic        busy2;

  regfile_mp dut0 (
    .clk(clk), .i_rst_n(rst_n), .i_raddr({raddr1, raddr0}), .o_rdata(rdata0),
    .i_waddr(waddr), .i_wdata(wdata), .i_wen(wen), .i_clr(clr), .o_busy(busy0),
    .i_dbg_addr(dbg_addr), .o_dbg_data(dbg0)
  );

  regfile_mp #(.BYPASS(0)) dut1 (
    .clk(clk), .i_rst_n(rst_n), .i_raddr({raddr1, raddr0}), .o_rdata(rdata1),
    .i_waddr(waddr), .i_wdata(wdata), .i_wen(wen), .i_clr(clr), .o_busy(busy1),
    .i_dbg_addr(dbg_addr), .o_dbg_data(dbg1)
  );

  regfile_mp #(.NUM_RD(4), .ADDR_WIDTH(3), .DATA_WIDTH(16)) dut2 (
    .clk(clk), .i_rst_n(rst_n), .i_raddr(d2_raddr), .o_rdata(rdata2),
    .i_waddr(d2_waddr), .i_wdata(d2_wdata), .i_wen(d2_wen), .i_clr(d2_clr),
    .o_busy(busy2), .i_dbg_addr(d2_dbg), .o_dbg_data(dbg2)
  );

  // ------------------------------------------------------------------
  // scoreboard
  // ------------------------------------------------------------------
  logic [31:0] exp_q[$];
  int          tag_q[$];
  int          n_chk  = 0;
  int          n_pass = 0;

  function automatic logic [31:0] act(input int t);
    case (t)
      0:  return rdata0[31:0];
      1:  return rdata0[63:32];
      2:  return dbg0;
      3:  return {31'b0, busy0};
      4:  return rdata1[63:32];
      5:  return {16'b0, rdata2[15:0]};
      6:  return {16'b0, rdata2[31:16]};
      7:  return {16'b0, rdata2[47:32]};
      8:  return {16'b0, rdata2[63:48]};
      9:  return {31'b0, busy2};
      10: return {31'b0, busy1};
      11: return dbg1;
      12: return {16'b0, dbg2};
      13: return rdata1[31:0];
      default: return 32'hxxxx_xxxx;
    endcase
  endfunction

  function automatic string tag_name(input int t);
    case (t)
      0:  return "dut0_rd0";
      1:  return "dut0_rd1";
      2:  return "dut0_dbg";
      3:  return "dut0_busy";
      4:  return "dut1_rd1";
      5:  return "dut2_rd0";
      6:  return "dut2_rd1";
      7:  return "dut2_rd2";
      8:  return "dut2_rd3";
      9:  return "dut2_busy";
      10: return "dut1_busy";
      11: return "dut1_dbg";
      12: return "dut2_dbg";
      13: return "dut1_rd0";
      default: return "unknown";
    endcase
  endfunction

  task automatic expect_chk(input int t, input logic [31:0] v);
    tag_q.push_back(t);
    exp_q.push_back(v);
  endtask

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      int          t;
      logic [31:0] e;
      logic [31:0] a;
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      a = act(t);
      n_chk++;
      if (a !== e)
        $display("FAIL %s @%0t: got %h expected %h", tag_name(t), $time, a, e);
      else
        n_pass++;
    end
  end

  // ------------------------------------------------------------------
  // driver
  // ------------------------------------------------------------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] d2_vals [8] = '{16'h0000, 16'h1111, 16'h2222, 16'h3333,
                               16'h4444, 16'h5555, 16'h6666, 16'h7777};

  initial begin
    rst_n = 1'b0;
    raddr0 = 5'd5; raddr1 = 5'd0; dbg_addr = 5'd5;
    waddr = 5'd5; wdata = 32'hDEADBEEF; wen = 1'b1; clr = 1'b0;
    d2_raddr = '0; d2_waddr = '0; d2_wdata = '0; d2_wen = 1'b0; d2_clr = 1'b0;
    d2_dbg = 3'd0;

    // in reset: outputs zero even with a forwarding-shaped write presented
    expect_chk(3, 32'h0);
    expect_chk(0, 32'h0);
    expect_chk(2, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wen   = 1'b0;
    cyc();

    // basic write then read
    wen = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; raddr0 = 5'd3;
    cyc();
    wen = 1'b0; raddr0 = 5'd5; raddr1 = 5'd5; dbg_addr = 5'd5;
    expect_chk(0, 32'hDEADBEEF);
    expect_chk(2, 32'hDEADBEEF);
    expect_chk(4, 32'hDEADBEEF);
    expect_chk(13, 32'hDEADBEEF);
    expect_chk(11, 32'hDEADBEEF);
    cyc();

    // forwarding vs. no forwarding; debug never forwards
    wen = 1'b1; waddr = 5'd7; wdata = 32'h12345678; raddr1 = 5'd7; dbg_addr = 5'd7;
    expect_chk(1, 32'h12345678);
    expect_chk(4, 32'h0);
    expect_chk(2, 32'h0);
    cyc();
    wen = 1'b0;
    expect_chk(1, 32'h12345678);
    expect_chk(4, 32'h12345678);
    cyc();

    // zero register
    wen = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF;
    raddr0 = 5'd0; raddr1 = 5'd0; dbg_addr = 5'd0;
    expect_chk(0, 32'h0);
    expect_chk(1, 32'h0);
    expect_chk(2, 32'h0);
    expect_chk(4, 32'h0);
    cyc();
    wen = 1'b0;
    expect_chk(0, 32'h0);
    expect_chk(1, 32'h0);
    expect_chk(2, 32'h0);
    cyc();

    // fill x1..x31 with their index
    for (int i = 1; i < 32; i++) begin
      wen = 1'b1; waddr = 5'(i); wdata = 32'(i);
      cyc();
    end

    // clear request coincident with a write to x30
    wen = 1'b1; waddr = 5'd30; wdata = 32'h300; clr = 1'b1;
    expect_chk(3, 32'h0);
    cyc();
    for (int c = 0; c < 32; c++) begin
      wen = 1'b1; waddr = 5'd3; wdata = 32'hBAD;
      clr = (c == 5 || c == 31);
      raddr0 = 5'd3; raddr1 = 5'd31; dbg_addr = 5'd30;
      expect_chk(3, 32'h1);
      expect_chk(10, 32'h1);
      expect_chk(0, (c > 3) ? 32'h0 : 32'h3);
      expect_chk(1, 32'd31);
      expect_chk(2, (c > 30) ? 32'h0 : 32'h300);
      cyc();
    end
    wen = 1'b0; clr = 1'b0;
    expect_chk(3, 32'h0);
    expect_chk(0, 32'h0);
    expect_chk(1, 32'h0);
    expect_chk(2, 32'h0);
    cyc();

    // reset in the middle of a clear
    wen = 1'b1; waddr = 5'd12; wdata = 32'h77;
    cyc();
    wen = 1'b0; clr = 1'b1;
    cyc();
    clr = 1'b0;
    repeat (10) cyc();
    rst_n = 1'b0; raddr0 = 5'd12; dbg_addr = 5'd12;
    expect_chk(3, 32'h0);
    expect_chk(0, 32'h0);
    expect_chk(2, 32'h0);
    cyc();
    rst_n = 1'b1;
    wen = 1'b1; waddr = 5'd9; wdata = 32'hA5A5A5A5;
    expect_chk(3, 32'h0);
    expect_chk(0, 32'h0);
    cyc();
    wen = 1'b0; raddr0 = 5'd9; dbg_addr = 5'd9;
    expect_chk(0, 32'hA5A5A5A5);
    expect_chk(2, 32'hA5A5A5A5);
    expect_chk(3, 32'h0);
    cyc();

    // narrow 4-port instance
    for (int i = 1; i < 8; i++) begin
      d2_wen = 1'b1; d2_waddr = 3'(i); d2_wdata = d2_vals[i];
      cyc();
    end
    d2_wen = 1'b0;
    d2_raddr = {3'd6, 3'd3, 3'd7, 3'd1};
    d2_dbg = 3'd6;
    expect_chk(5, 32'h1111);
    expect_chk(6, 32'h7777);
    expect_chk(7, 32'h3333);
    expect_chk(8, 32'h6666);
    expect_chk(12, 32'h6666);
    cyc();
    d2_clr = 1'b1;
    expect_chk(9, 32'h0);
    cyc();
    d2_clr = 1'b0;
    for (int c = 0; c < 8; c++) begin
      expect_chk(9, 32'h1);
      expect_chk(8, (c > 6) ? 32'h0 : 32'h6666);
      cyc();
    end
    expect_chk(9, 32'h0);
    expect_chk(5, 32'h0);
    expect_chk(6, 32'h0);
    cyc();

    @(negedge clk);
    #1;
    if (exp_q.size() != 0)
      $display("FAIL scoreboard: got %0d pending expected 0", exp_q.size());
    if (n_chk == 0)
      $display("FAIL scoreboard: got 0 checks expected some");
    if (n_pass != n_chk)
      $display("FAIL %0d/%0d checks passed", n_pass, n_chk);
    else
      $display("PASS %0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
